tinker_fetch_unit: RTL and testbench
====================================

Name: tinker_fetch_unit

Overview:
- Instruction-fetch front end for the 5-stage Tinker pipeline; it produces the {PC, instruction} pairs that load the IF/ID register.
- Issues in-order word requests to the instruction-memory port and buffers returned words in a DEPTH-entry prefetch queue.
- Presents queue entries to decode through a valid/ready handshake.
- Handles redirects from EX (jump/branch/call/return) by flushing the queue and discarding responses still in flight.
- Detects the halt instruction and stops fetching.

Parameters:
DEPTH, 4, prefetch queue entries; also the maximum number of outstanding requests (power of 2, >=2)
RESET_PC, 64'h2000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  byte address of requested word
imem_resp_valid  in  1  response word valid (in request order, >=1 cycle after acceptance)
imem_resp_data  in  32  instruction word
redirect_valid  in  1  EX redirect pulse
redirect_pc  in  64  redirect target
if_valid  out  1  head entry valid to decode
if_ready  in  1  decode accepts head entry
if_pc  out  64  PC of head entry
if_instr  out  32  instruction of head entry
halted  out  1  halt instruction consumed by decode

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset=0:
  - if_valid=0, imem_req_valid=0, halted=0.
  - imem_req_addr=RESET_PC, if_pc=0, if_instr=0.
  - Queue empty; outstanding=0; drop_cnt=0; state=FETCH.
- Reset asserting mid-operation discards everything immediately. Responses arriving after reset is released are accepted as new data, so the memory is reset together with this block.
- Handshakes:
  - A request transfers when imem_req_valid & imem_req_ready.
  - The head entry is consumed when if_valid & if_ready.
  - if_valid and if_pc/if_instr change only at clock edges, except for the redirect gating below.
- Request issue:
  - imem_req_valid=1 when state==FETCH, redirect_valid==0, and occupancy+outstanding < DEPTH.
  - Each accepted request advances fetch_pc by 4, modulo 2^64.
  - outstanding increments on acceptance and decrements on each response.
- Responses:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it is written to the tail as {pc_tag, data}. pc_tag comes from an internal in-order tag counter that starts at the fetch address and advances by 4 per accepted response.
  - A written entry becomes visible at the head no earlier than the next cycle; there is no bypass.
  - Minimum latency: request accepted in cycle N, response in N+1, if_valid in N+2. First if_valid comes 3 cycles after reset release.
  - A response with outstanding==0 is a protocol violation and is ignored.
- Queue:
  - Circular buffer with log2(DEPTH)+1-bit pointers.
  - Full when occupancy==DEPTH; issue throttling guarantees a write is never attempted while full.
  - Enqueue and dequeue in the same cycle leave occupancy unchanged.
- Redirect (redirect_valid=1):
  - Redirect has priority over every other event in the same cycle.
  - if_valid is forced to 0 combinationally, so no dequeue occurs.
  - imem_req_valid is forced to 0.
  - At the edge:
    - queue flushed;
    - fetch_pc and tag are set to {redirect_pc[63:2],2'b00};
    - drop_cnt set to outstanding minus (1 if a response arrives this cycle);
    - state set to FETCH, unless state==HALTED.
  - Fetching resumes the next cycle.
- States:
  - FETCH: normal operation. On enqueuing a halt word (imem_resp_data[31:27]==5'h0f and [11:8]==4'h0), go to HALT_DRAIN. In that same edge, set drop_cnt=outstanding-1 (fetches beyond the halt are discarded).
  - HALT_DRAIN: no new requests; decode drains the queue. When the halt entry is consumed, go to HALTED and assert halted=1 from the next cycle. A redirect returns the block to FETCH, because the halt was on the wrong path.
  - HALTED: no requests and if_valid=0; halted stays 1 until reset. Redirects are ignored.

Test Plan:
- Reset to 0, then released. Memory is always ready, 1-cycle latency, returns 32'h11111111 etc. Expect: request addresses 2000, 2004, 2008…; first if_valid 3 cycles after release with if_pc=2000; one instruction per cycle with if_ready=1.
- if_ready=0 held. Expect: exactly DEPTH=4 requests (2000–200C) issued, then imem_req_valid=0. Raising if_ready delivers 2000, 2004, 2008, 200C in order and fetching resumes at 2010.
- Memory latency 3 cycles with 2 requests outstanding; redirect_pc=64'h3002. Expect: queue flushed; both late responses dropped; next request address 3000; next if_pc=3000.
- Redirect in the same cycle as if_ready=1 and a response arrival. Expect: no dequeue, the response is dropped, drop_cnt is correct, no stale PC appears afterwards.
- Word 32'h78000000 at 2008. Expect: no requests after its acceptance; 2000, 2004, 2008 delivered; halted=1 the cycle after 2008 is consumed; halted stays 1 with redirects ignored.
- Halt enqueued, then redirect to 4000 before it is consumed. Expect: halted stays 0 and fetching resumes at 4000.

Source files
------------

// File: rtl/tinker_fetch_unit.sv
// Tinker instruction-fetch front end: issues in-order word fetches, buffers
// returned words in a prefetch queue, and hands {pc, instr} pairs to decode.
//
// Handshakes: every transfer is valid & ready in the same cycle. A valid
// never depends combinationally on its own ready. imem requests transfer on
// imem_req_valid & imem_req_ready, the queue head is consumed on
// if_valid & if_ready, and a response is taken on any cycle with
// imem_resp_valid while requests are outstanding.
module tinker_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          run_q, run_d;
    logic          halted_q, halted_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   tag_q, tag_d;
    logic [PW-1:0] outstanding_q, outstanding_d;
    logic [PW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Queue storage; validity is carried entirely by the pointers.
    logic [63:0]   ent_pc_q    [DEPTH];
    logic [31:0]   ent_instr_q [DEPTH];

    logic [PW-1:0] occ;
    logic [PW:0]   in_flight;
    logic          q_empty;
    logic          req_fire;
    logic          resp_acc;
    logic          resp_keep;
    logic          redir_act;
    logic          enq;
    logic          deq;
    logic          is_halt;
    logic [63:0]   redir_aligned;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // Handshake qualifiers and head-of-queue outputs.
    always_comb begin
        occ            = wr_ptr_q - rd_ptr_q;
        q_empty        = (occ == '0);
        in_flight      = {1'b0, occ} + {1'b0, outstanding_q};
        rd_idx         = rd_ptr_q[AW-1:0];
        wr_idx         = wr_ptr_q[AW-1:0];
        redir_aligned  = redirect_pc & ~64'd3;
        // run_q holds issue off for the first cycle after reset release.
        imem_req_valid = run_q && (state_q == ST_FETCH) && !redirect_valid
                         && (in_flight < (PW+1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        if_valid       = !q_empty && (state_q != ST_HALTED) && !redirect_valid;
        if_pc          = q_empty ? 64'd0 : ent_pc_q[rd_idx];
        if_instr       = q_empty ? 32'd0 : ent_instr_q[rd_idx];
        halted         = halted_q;
        dbg_state      = state_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol violation; ignore it.
        resp_acc       = imem_resp_valid && (outstanding_q != '0);
        resp_keep      = resp_acc && (drop_cnt_q == '0);
        redir_act      = redirect_valid && (state_q != ST_HALTED);
        enq            = resp_keep && !redirect_valid && (state_q != ST_HALTED);
        deq            = if_valid && if_ready;
        is_halt        = (imem_resp_data[31:27] == 5'h0f) && (imem_resp_data[11:8] == 4'h0);
        outstanding_d  = outstanding_q + PW'(req_fire) - PW'(resp_acc);
    end

    // Next-state logic: normal fetch/queue updates first, redirect overrides last.
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        halted_d   = halted_q;
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        drop_cnt_d = drop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (resp_acc && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - PW'(1);
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            tag_d    = tag_q + 64'd4;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            ST_FETCH: begin
                // Everything still in flight (including a request issued this
                // cycle) lies past the halt and must be thrown away.
                if (enq && is_halt) begin
                    state_d    = ST_HALT_DRAIN;
                    drop_cnt_d = outstanding_d;
                end
            end
            ST_HALT_DRAIN: begin
                // The halt is the youngest entry, so it is the head once occ==1.
                if (deq && (occ == PW'(1))) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (redir_act) begin
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            fetch_pc_d = redir_aligned;
            tag_d      = redir_aligned;
            // A response arriving this cycle is already excluded by outstanding_d.
            drop_cnt_d = outstanding_d;
            state_d    = ST_FETCH;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            run_q         <= 1'b0;
            halted_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            tag_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            halted_q      <= halted_d;
            fetch_pc_q    <= fetch_pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Queue storage write at the tail; no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_pc_q[wr_idx]    <= tag_q;
            ent_instr_q[wr_idx] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Bench for tinker_fetch_unit: in-order memory model, delivery scoreboard,
// a per-cycle vector table for the start-up sequence and directed sequences.
module tb_tinker_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic [1:0]  dbg_state;

    tinker_fetch_unit #(.DEPTH(4), .RESET_PC(64'h2000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .halted          (halted),
        .dbg_state       (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bench state
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    bit          ready_cfg = 1'b1;
    logic [63:0] halt_addr = 64'h0;

    logic [63:0] p_addr[$];
    int          p_due[$];
    logic [63:0] acc_q[$];
    logic [95:0] exp_q[$];

    logic        s_req_valid, s_if_valid, s_halted;
    logic [63:0] s_req_addr, s_if_pc;
    logic [31:0] s_if_instr;
    logic [1:0]  s_state;

    typedef struct {
        bit          rdy;
        bit          exp_req_valid;
        logic [63:0] exp_addr;
        bit          exp_if_valid;
        logic [63:0] exp_if_pc;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == halt_addr) return 32'h78000000;
        return {16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [63:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_q.push_back({pc, word(pc)});
    endtask

    // Driver: one clock cycle. Inputs change on the falling edge, outputs are
    // sampled 1ns later, then the scoreboard and memory model advance.
    task automatic cycle(input bit rdy, input bit redir, input logic [63:0] rpc);
        logic [95:0] e;
        @(negedge clk);
        reset          = 1'b1;
        imem_req_ready = ready_cfg;
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        s_halted    = halted;
        s_state     = dbg_state;
        if (s_if_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h expected nothing", s_if_pc, s_if_instr);
            end else begin
                e = exp_q.pop_front();
                if ({s_if_pc, s_if_instr} !== e) begin
                    failures++;
                    $display("FAIL sb_delivery: got pc=%h instr=%h expected pc=%h instr=%h",
                             s_if_pc, s_if_instr, e[95:32], e[31:0]);
                end
            end
        end
        if (s_req_valid && ready_cfg) begin
            p_addr.push_back(s_req_addr);
            p_due.push_back(cyc + mem_lat);
            acc_q.push_back(s_req_addr);
        end
        if (p_due.size() > 0 && p_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(p_addr.pop_front());
            void'(p_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        cyc++;
    endtask

    // Asserts reset asynchronously mid-cycle, checks reset outputs, clears the model.
    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        if_ready        = 1'b0;
        p_addr.delete();
        p_due.delete();
        acc_q.delete();
        exp_q.delete();
        cyc = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req_addr", imem_req_addr, 64'h2000);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) cycle(1, 0, 64'h0);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; if_ready = 1'b0;

        // Start-up sequence, cycle 0 is the reset-release cycle.
        vecs[0] = '{1, 0, 64'h2000, 0, 64'h0};
        vecs[1] = '{1, 1, 64'h2000, 0, 64'h0};
        vecs[2] = '{1, 1, 64'h2004, 0, 64'h0};
        vecs[3] = '{1, 1, 64'h2008, 1, 64'h2000};
        vecs[4] = '{1, 1, 64'h200C, 1, 64'h2004};
        vecs[5] = '{1, 1, 64'h2010, 1, 64'h2008};

        // Streaming with decode always ready
        mem_lat = 1; ready_cfg = 1; halt_addr = 64'h0;
        do_reset();
        push_exp(64'h2000); push_exp(64'h2004); push_exp(64'h2008);
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].rdy, 0, 64'h0);
            chk($sformatf("v%0d_req_valid", i), s_req_valid, vecs[i].exp_req_valid);
            if (vecs[i].exp_req_valid) chk($sformatf("v%0d_req_addr", i), s_req_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_if_valid", i), s_if_valid, vecs[i].exp_if_valid);
            chk($sformatf("v%0d_if_pc", i), s_if_pc, vecs[i].exp_if_pc);
        end
        chk("t1_all_delivered", exp_q.size(), 0);

        // Decode stalled: issue throttles at DEPTH, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 0, 64'h0);
        chk("t2_req_count", acc_q.size(), 4);
        chk("t2_req_stopped", s_req_valid, 0);
        chk("t2_head_pc", s_if_pc, 64'h2000);
        chk("t2_last_req", acc_at(3), 64'h200C);
        push_exp(64'h2000); push_exp(64'h2004); push_exp(64'h2008);
        push_exp(64'h200C); push_exp(64'h2010);
        run_drain("t2_drain", 30);
        chk("t2_resume_addr", acc_at(4), 64'h2010);

        // Redirect with two late responses in flight (latency 3)
        mem_lat = 3; ready_cfg = 1;
        do_reset();
        cycle(1, 0, 64'h0);
        cycle(1, 0, 64'h0);
        cycle(1, 0, 64'h0);
        ready_cfg = 0;
        cycle(1, 1, 64'h3002);
        chk("t3_redir_req_gated", s_req_valid, 0);
        chk("t3_redir_if_gated", s_if_valid, 0);
        chk("t3_reqs_before", acc_q.size(), 2);
        ready_cfg = 1;
        base = acc_q.size();
        cycle(1, 0, 64'h0);
        chk("t3_next_req_addr", acc_at(base), 64'h3000);
        push_exp(64'h3000); push_exp(64'h3004); push_exp(64'h3008);
        run_drain("t3_drain", 40);

        // Redirect coinciding with if_ready and a response arrival
        mem_lat = 1; ready_cfg = 1;
        do_reset();
        push_exp(64'h2000); push_exp(64'h2004);
        for (int i = 0; i < 5; i++) cycle(1, 0, 64'h0);
        chk("t4_pre_delivered", exp_q.size(), 0);
        cycle(1, 1, 64'h5000);
        chk("t4_if_gated", s_if_valid, 0);
        chk("t4_req_gated", s_req_valid, 0);
        chk("t4_resp_in_flight", imem_resp_valid, 1);
        base = acc_q.size();
        push_exp(64'h5000); push_exp(64'h5004);
        run_drain("t4_drain", 20);
        chk("t4_next_req_addr", acc_at(base), 64'h5000);

        // Halt word at 2008, redirects ignored once halted
        halt_addr = 64'h2008;
        do_reset();
        push_exp(64'h2000); push_exp(64'h2004); push_exp(64'h2008);
        for (int i = 0; i < 6; i++) cycle(1, 0, 64'h0);
        chk("t5_halt_not_yet", s_halted, 0);
        chk("t5_state_drain", s_state, 2'd1);
        cycle(1, 0, 64'h0);
        chk("t5_halted", s_halted, 1);
        chk("t5_halt_no_if", s_if_valid, 0);
        chk("t5_req_count", acc_q.size(), 4);
        cycle(1, 1, 64'h6000);
        cycle(1, 0, 64'h0);
        cycle(1, 0, 64'h0);
        chk("t5_stays_halted", s_halted, 1);
        chk("t5_no_req", s_req_valid, 0);
        chk("t5_no_new_acc", acc_q.size(), 4);
        chk("t5_state_halted", s_state, 2'd2);
        chk("t5_all_delivered", exp_q.size(), 0);

        // Halt enqueued, then redirected away before decode consumes it
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 0, 64'h0);
        chk("t6_state_drain", s_state, 2'd1);
        cycle(0, 1, 64'h4000);
        cycle(0, 0, 64'h0);
        chk("t6_resume_req", s_req_valid, 1);
        chk("t6_resume_addr", s_req_addr, 64'h4000);
        push_exp(64'h4000); push_exp(64'h4004);
        run_drain("t6_drain", 20);
        chk("t6_not_halted", s_halted, 0);

        // Reset while halted-capable state is dirty
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
